sequenciador_teste_porta: RTL and testbench
===========================================

Name: sequenciador_teste_porta

Overview:
Self-test controller for a 2-input combinational gate (AND, OR, XOR, ...). On a start pulse it drives the gate's two inputs through all four combinations (00, 01, 10, 11). It holds each vector for a settle time, samples the gate output and compares it against an expected truth table. It reports pass/fail, a mismatch count and a per-vector failure mask, and sits beside the gate as its on-chip sequencer/checker.

Parameters:
HOLD_CYCLES, 2, settle cycles each vector is held before sampling; 0 is treated as 1.
EXP_TT, 4'b1000, expected gate output indexed by vector {a,b}; bit i is the expected y for vector i. Default is AND.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin test run; sampled only in IDLE
gate_y  in  1  output of the gate under test
gate_a  out  1  gate input a (= vec_idx[1]); registered
gate_b  out  1  gate input b (= vec_idx[0]); registered
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse; run complete
pass  out  1  high when the last completed run had err_count==0; held until next start
err_count  out  3  mismatches in the last/current run, 0..4
fail_vec  out  4  bit i set if vector i mismatched
vec_idx  out  2  index of the vector currently applied

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset (any state, including mid-run): state=IDLE, and every output becomes 0 on the same edge: gate_a, gate_b, busy, done, pass, err_count, fail_vec, vec_idx.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at edge E:
  - vec_idx<=0, gate_a/gate_b<=0/0.
  - err_count<=0, fail_vec<=0, pass<=0, busy<=1.
  - settle counter<=H, where H=max(HOLD_CYCLES,1); state<=SETTLE.
- SETTLE: counter decrements each edge. When counter==1, state<=CHECK. SETTLE therefore lasts exactly H cycles.
- CHECK: gate_y is sampled at this edge. Mismatch (gate_y != EXP_TT[vec_idx]): err_count<=err_count+1 and fail_vec[vec_idx]<=1.
  - vec_idx==3: state<=DONE and busy<=0 on that edge.
  - Otherwise: vec_idx<=vec_idx+1, gate_a/gate_b updated to the new index, counter<=H, state<=SETTLE.
- Per-vector time is H+1 cycles. DONE is entered at edge E+4*(H+1).
- DONE: done=1 for exactly one cycle; pass=(err_count==0) is registered on entry. Next edge goes to IDLE.
- After DONE: gate_a/gate_b/vec_idx hold 1/1/3; err_count, fail_vec and pass hold until the next accepted start.
- start while busy or in DONE: ignored; no restart and no queuing.
- start held high continuously: a new run begins on the first IDLE edge after DONE.
- X/Z on gate_y counts as a mismatch (bench uses known values only).

Decomposition:
- Shared include header (`include style) holds:
  - state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3.
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001.
- One natural sub-module: contador_espera (loadable down-counter with terminal flag) implementing the settle timer. Everything else stays in the top FSM.

Test Plan:
1. rst=1 for 2 cycles with start=1 -> all outputs 0 and FSM stays IDLE; then rst=0, start=0 -> still idle, busy=0.
2. Bench gate y=a&b, H=2, default EXP_TT, 1-cycle start -> vectors 00,01,10,11 each held 3 cycles; done pulses at start edge+12; pass=1, err_count=0, fail_vec=0000.
3. Faulty gate y=a|b, EXP_TT=TT_AND -> err_count=2, fail_vec=0110, pass=0, done at +12.
4. gate_y stuck at 1, EXP_TT=TT_AND -> err_count=3, fail_vec=0111, pass=0. Rerun with y=a^b, EXP_TT=TT_XOR, HOLD_CYCLES=0 -> done at +8 and pass=1.
5. start held high during run -> no restart until after DONE. rst asserted while vec_idx=2 -> next edge busy=0, gate_a/b=0, err_count=0, fail_vec=0. A fresh start then completes normally.
6. Run with y=a|b (err_count=2), then start again with a correct gate -> err_count/fail_vec cleared on the start edge; second run gives pass=1.

Source files
------------

// File: rtl/sequenciador_teste_porta_pkg.sv
// Shared definitions for the gate self-test sequencer: FSM encodings,
// common truth tables and the settle-time helper.
package sequenciador_teste_porta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // A zero hold would leave no settle cycle at all, so it is promoted to one.
    function automatic int hold_eff(input int h);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/sequenciador_teste_porta_contador_espera.sv
// Loadable down-counter used as the per-vector settle timer; term_o flags
// the last cycle of the hold window (count == 1).
module contador_espera #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == W'(1));

endmodule

// File: rtl/sequenciador_teste_porta.sv
// On-chip sequencer/checker for a 2-input gate: walks vectors 00..11, holds
// each for the settle time, samples gate_y and accumulates mismatches.
module sequenciador_teste_porta
    import sequenciador_teste_porta_pkg::*;
#(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [3:0] EXP_TT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [1:0] vec_idx,
    output logic [1:0] dbg_state
);

    localparam int H     = hold_eff(HOLD_CYCLES);
    localparam int CNT_W = (H < 2) ? 1 : $clog2(H + 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cnt_load;
    logic       cnt_term;
    logic       mismatch;
    logic [CNT_W-1:0] cnt_val;

    contador_espera #(.W(CNT_W)) u_espera (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(H)),
        .count_o    (cnt_val),
        .term_o     (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        // Written so an unknown gate_y falls through as a mismatch.
        mismatch = 1'b1;
        if (gate_y == EXP_TT[vec_q]) begin
            mismatch = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d    = 2'd0;
                    err_d    = 3'd0;
                    fail_d   = 4'd0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_term) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d         = err_q + 3'd1;
                    fail_d[vec_q] = 1'b1;
                end
                if (vec_q == 2'd3) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    vec_d    = vec_q + 2'd1;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gate_a    = vec_q[1];
    assign gate_b    = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sequenciador_teste_porta.sv
// Bench for sequenciador_teste_porta: two instances (AND/hold 2 and
// XOR/hold 0) each driving a behavioural gate whose function is selectable.
module tb_sequenciador_teste_porta;
    import sequenciador_teste_porta_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start0 = 1'b0, start1 = 1'b0;
    int   mode0 = 0, mode1 = 3;
    logic a0, b0, y0, busy0, done0, pass0;
    logic a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;
    logic [1:0] vec0, vec1, st0, st1;

    // Gate under test: 0 AND, 1 OR, 2 stuck-at-1, other XOR.
    function automatic logic gate_fn(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return a | b;
            2:       return 1'b1;
            default: return a ^ b;
        endcase
    endfunction

    assign y0 = gate_fn(mode0, a0, b0);
    assign y1 = gate_fn(mode1, a1, b1);

    sequenciador_teste_porta #(.HOLD_CYCLES(2), .EXP_TT(TT_AND)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_y(y0),
        .gate_a(a0), .gate_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0), .vec_idx(vec0), .dbg_state(st0)
    );

    sequenciador_teste_porta #(.HOLD_CYCLES(0), .EXP_TT(TT_XOR)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_y(y1),
        .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1), .vec_idx(vec1), .dbg_state(st1)
    );

    // Selected-instance view.
    int sel = 0;
    logic m_a, m_b, m_busy, m_done, m_pass;
    logic [2:0] m_err;
    logic [3:0] m_fail;
    logic [1:0] m_vec, m_st;
    always_comb begin
        m_a = a0; m_b = b0; m_busy = busy0; m_done = done0; m_pass = pass0;
        m_err = err0; m_fail = fail0; m_vec = vec0; m_st = st0;
        if (sel == 1) begin
            m_a = a1; m_b = b1; m_busy = busy1; m_done = done1; m_pass = pass1;
            m_err = err1; m_fail = fail1; m_vec = vec1; m_st = st1;
        end
    end

    // ---------------- scoreboard ----------------
    // Entry: {latency[7:0], pass, err_count[2:0], fail_vec[3:0]}
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     32'(m_a),    0);
        check({tag, "_b"},     32'(m_b),    0);
        check({tag, "_busy"},  32'(m_busy), 0);
        check({tag, "_done"},  32'(m_done), 0);
        check({tag, "_pass"},  32'(m_pass), 0);
        check({tag, "_err"},   32'(m_err),  0);
        check({tag, "_fail"},  32'(m_fail), 0);
        check({tag, "_vec"},   32'(m_vec),  0);
        check({tag, "_state"}, 32'(m_st),   32'(ST_IDLE));
    endtask

    // ---------------- driver ----------------
    task automatic run_test(input int s, input int mode, input bit hold, input bit trace);
        int h, lat, errs, ev;
        logic [3:0] tt, act, mis;
        logic [15:0] e;
        sel = s;
        if (s == 0) begin
            mode0 = mode; h = 2; tt = TT_AND;
        end else begin
            mode1 = mode; h = 1; tt = TT_XOR;
        end
        for (int v = 0; v < 4; v++) begin
            act[v] = gate_fn(mode, v[1], v[0]);
        end
        mis  = act ^ tt;
        errs = 0;
        for (int v = 0; v < 4; v++) errs += int'(mis[v]);
        exp_q.push_back({8'(4 * (h + 1)), (errs == 0), 3'(errs), mis});

        @(negedge clk);
        if (s == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start0 = 1'b0;
            start1 = 1'b0;
        end

        lat = 0;
        forever begin
            @(negedge clk);
            if (lat == 0) begin
                check("start_clr_err",  32'(m_err),  0);
                check("start_clr_fail", 32'(m_fail), 0);
                check("start_clr_pass", 32'(m_pass), 0);
                check("start_busy",     32'(m_busy), 1);
            end
            if (trace) begin
                ev = lat / (h + 1);
                if (ev > 3) ev = 3;
                check("trace_vec", 32'(m_vec), 32'(ev));
                check("trace_ab",  32'({m_a, m_b}), 32'(ev));
                check("trace_busy", 32'(m_busy), (lat < 4 * (h + 1)) ? 1 : 0);
            end
            if (m_done) break;
            if (lat >= 100) begin
                check("done_timeout", 32'(lat), 32'(4 * (h + 1)));
                break;
            end
            @(posedge clk);
            lat++;
        end

        e = exp_q.pop_front();
        check("latency",  32'(lat),    32'(e[15:8]));
        check("pass",     32'(m_pass), 32'(e[7]));
        check("err",      32'(m_err),  32'(e[6:4]));
        check("fail_vec", 32'(m_fail), 32'(e[3:0]));
        check("done_busy", 32'(m_busy), 0);
        check("done_vec", 32'(m_vec), 3);
        @(negedge clk);
        check("done_pulse", 32'(m_done), 0);
        check("post_state", 32'(m_st), 32'(ST_IDLE));
        check("hold_pass", 32'(m_pass), 32'(e[7]));
        check("hold_err",  32'(m_err),  32'(e[6:4]));
    endtask

    // ---------------- sequence ----------------
    initial begin
        int waited;
        // Reset with start asserted: nothing may start.
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sel = 0; #0 check_all_zero("rst0");
        sel = 1; #0 check_all_zero("rst1");
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        sel = 0; #0 check("idle_busy0", 32'(m_busy), 0);
        check("idle_state0", 32'(m_st), 32'(ST_IDLE));

        run_test(0, 0, 1'b0, 1'b1);   // good AND gate, full trace
        run_test(0, 1, 1'b0, 1'b0);   // OR against AND table
        run_test(0, 2, 1'b0, 1'b0);   // stuck-at-1
        run_test(1, 3, 1'b0, 1'b1);   // XOR, hold 0 -> 8 cycles
        run_test(1, 0, 1'b0, 1'b0);   // AND against XOR table
        for (int i = 0; i < 3; i++) begin
            run_test(0, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        run_test(0, 1, 1'b0, 1'b0);   // failing run then clean rerun
        run_test(0, 0, 1'b0, 1'b0);

        // start held: no restart during the run, new run after DONE.
        run_test(0, 1, 1'b1, 1'b0);
        check("held_idle_busy", 32'(m_busy), 0);
        @(negedge clk);
        check("held_restart_busy", 32'(m_busy), 1);
        waited = 0;
        while (m_vec != 2'd2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("reach_vec2", 32'(m_vec), 2);
        check("mid_err", 32'(m_err), 1);
        start0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        run_test(0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
